gpu_cmd_fifo: RTL

//  Write-side partner of the GPU command controller. Assembles 4-beat, 32-bit host

---
 rtl/gpu_cmd_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// gpu_cmd_fifo
//   Write-side partner of the GPU command controller. Host writes arrive as
//   32-bit beats, four per draw command. The first three beats are held in a
//   staging register. The fourth beat completes the command, which is then
//   queued. Commands whose opcode no draw engine acknowledges are discarded
//   instead of queued, so the controller never waits on an engine that will
//   not respond. The head of the queue is presented as decoded fields.
//
// Ports
//   clk           rising-edge clock
//   n_rst         asynchronous reset, active low
//   clear_i       synchronous flush of the partial command and the whole queue
//   wr_valid_i    host beat valid
//   wr_data_i     host beat data (32 bits)
//   wr_ready_o    beat accepted when wr_valid_i & wr_ready_o
//   drop_o        one-cycle pulse: an assembled command was discarded
//   pop_i         controller retires the head entry
//   fifo_empty_o  no complete command queued
//   count_o       number of queued commands (0..DEPTH)
//   opcode_o, oct_o, r_o, g_o, b_o, x1_o, y1_o, x2_o, y2_o, rad_o
//                 head-entry fields, all zero while the queue is empty
// -----------------------------------------------------------------------------
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WB    = 10,
  parameter int HB    = 9,
  parameter int CB    = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear_i,
  input  logic                       wr_valid_i,
  input  logic [31:0]                wr_data_i,
  output logic                       wr_ready_o,
  output logic                       drop_o,
  input  logic                       pop_i,
  output logic                       fifo_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [3:0]                 opcode_o,
  output logic [WB-1:0]              x1_o,
  output logic [WB-1:0]              x2_o,
  output logic [WB-1:0]              rad_o,
  output logic [HB-1:0]              y1_o,
  output logic [HB-1:0]              y2_o,
  output logic [CB-1:0]              r_o,
  output logic [CB-1:0]              g_o,
  output logic [CB-1:0]              b_o,
  output logic [2:0]                 oct_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] OP_LINE = 4'b0100;
  localparam logic [3:0] OP_FILL = 4'b0101;
  localparam logic [3:0] OP_ARC  = 4'b0111;

  typedef struct packed {
    logic [3:0]    opcode;
    logic [2:0]    oct;
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
    logic [WB-1:0] x1;
    logic [HB-1:0] y1;
    logic [WB-1:0] x2;
    logic [HB-1:0] y2;
    logic [WB-1:0] rad;
  } entry_t;

  // Beat assembly state
  logic [1:0]    beat_cnt_reg;
  entry_t        stage_reg;

  // Queue state
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          drop_reg;

  // Handshake / control decode
  logic   full;
  logic   empty;
  logic   is_last_beat;
  logic   beat_fire;
  logic   last_fire;
  logic   op_ok;
  logic   do_push;
  logic   do_pop;
  logic   do_drop;
  entry_t new_entry;
  entry_t head;

  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign is_last_beat = (beat_cnt_reg == 2'd3);

  // Only the completing beat can be back-pressured; a full queue holds it
  // even if the controller pops in the same cycle (ready is from registered
  // count, so the freed slot is seen one cycle later).
  assign wr_ready_o = !is_last_beat || !full;
  assign beat_fire  = wr_valid_i && wr_ready_o;
  assign last_fire  = beat_fire && is_last_beat;

  assign op_ok = (stage_reg.opcode == OP_LINE) ||
                 (stage_reg.opcode == OP_FILL) ||
                 (stage_reg.opcode == OP_ARC);

  // A flush wins over anything happening in the same cycle.
  assign do_push = last_fire && op_ok  && !clear_i;
  assign do_drop = last_fire && !op_ok && !clear_i;
  assign do_pop  = pop_i && !empty && !clear_i;

  // The completed entry is the staged fields plus the radius from beat 3.
  always_comb begin
    new_entry     = stage_reg;
    new_entry.rad = wr_data_i[WB-1:0];
  end

  // Beat counter and staging register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      beat_cnt_reg <= 2'd0;
      stage_reg    <= '0;
    end else if (clear_i) begin
      beat_cnt_reg <= 2'd0;
    end else if (beat_fire) begin
      beat_cnt_reg <= beat_cnt_reg + 2'd1;
      case (beat_cnt_reg)
        2'd0: begin
          stage_reg.opcode <= wr_data_i[31:28];
          stage_reg.oct    <= wr_data_i[26:24];
          stage_reg.r      <= wr_data_i[3*CB-1:2*CB];
          stage_reg.g      <= wr_data_i[2*CB-1:CB];
          stage_reg.b      <= wr_data_i[CB-1:0];
        end
        2'd1: begin
          stage_reg.x1 <= wr_data_i[WB-1:0];
          stage_reg.y1 <= wr_data_i[16+HB-1:16];
        end
        2'd2: begin
          stage_reg.x2 <= wr_data_i[WB-1:0];
          stage_reg.y2 <= wr_data_i[16+HB-1:16];
        end
        default: ;
      endcase
    end
  end

  // Entry storage: written only on a push, never reset (the head is masked
  // to zero while empty, so stale contents are never visible).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= new_entry;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, occupancy and drop pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      drop_reg <= do_drop;
      if (clear_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (do_pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        count_reg <= count_next;
      end
    end
  end

  // Head entry is read combinationally so the controller sees it the same
  // cycle the pointer moves; it is stable until popped.
  always_comb begin
    head = mem[rd_ptr_reg];
    if (empty) begin
      head = '0;
    end
  end

  assign fifo_empty_o = empty;
  assign count_o      = count_reg;
  assign drop_o       = drop_reg;
  assign opcode_o     = head.opcode;
  assign oct_o        = head.oct;
  assign r_o          = head.r;
  assign g_o          = head.g;
  assign b_o          = head.b;
  assign x1_o         = head.x1;
  assign y1_o         = head.y1;
  assign x2_o         = head.x2;
  assign y2_o         = head.y2;
  assign rad_o        = head.rad;

endmodule
